// File: rtl/grf_wq_pkg.sv
// GRF write queue: shared constants and the queued-entry type.
// Used by the ring buffer, the bus interface and the top.
package grf_wq_pkg;

    localparam int AW            = 5;
    localparam int DW            = 32;
    localparam int DEPTH_DEFAULT = 4;
    localparam int PTR_W         = $clog2(DEPTH_DEFAULT);

    typedef struct packed {
        logic          live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/grf_write_queue_if.sv
// GRF write queue bus: pipeline writeback, secondary source,
// GRF port and decode-side status.
interface grf_write_queue_if
    import grf_wq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [AW-1:0] grf_a3;
    logic [DW-1:0] grf_wd;
    logic [31:0]   pend_mask;
    logic [CW-1:0] count;

    modport master (
        output w_en, w_addr, w_data,
        output s_valid, s_addr, s_data,
        input  s_ready,
        input  grf_a3, grf_wd,
        input  pend_mask, count
    );

    modport slave (
        input  w_en, w_addr, w_data,
        input  s_valid, s_addr, s_data,
        output s_ready,
        output grf_a3, grf_wd,
        output pend_mask, count
    );

endinterface

// File: rtl/grf_wq_ring.sv
// Circular buffer of pending GRF writes with kill-by-address.
// An entry's live bit is cleared on pop, so live implies occupied.
module grf_wq_ring
    import grf_wq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          kill,
    input  logic [AW-1:0] kill_addr,
    output wq_entry_t     head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic [31:0]   pend_mask
);

    wq_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;

    assign head  = mem[rd_ptr];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;

    // Kill older matches, retire the popped slot, then land the push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && mem[i].addr == kill_addr) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
            end
            if (push) begin
                mem[wr_ptr] <= '{live: 1'b1,
                                 addr: push_addr,
                                 data: push_data};
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // One-hot per live entry; register 0 never reports pending.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) begin
                pend_mask = pend_mask | (32'(1) << mem[i].addr);
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: rtl/grf_write_queue.sv
// GRF single write port arbiter: pipeline first, queued results next.
// Optional trace print enabled by defining GRF_WQ_TRACE_EN.
module grf_write_queue
    import grf_wq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    grf_write_queue_if.slave bus
);

    wq_entry_t     head;
    logic          empty;
    logic          full;
    logic          w_issue;
    logic          push;
    logic          pop;
    logic [AW-1:0] a3_q;
    logic [DW-1:0] wd_q;

    assign w_issue = bus.w_en && (bus.w_addr != '0);
    assign pop     = !w_issue && !empty;
    assign push    = bus.s_valid && !full
                   && (bus.s_addr != '0);

    assign bus.s_ready = !full;
    assign bus.grf_a3  = a3_q;
    assign bus.grf_wd  = wd_q;

    grf_wq_ring #(.DEPTH(DEPTH)) u_ring (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_addr (bus.s_addr),
        .push_data (bus.s_data),
        .pop       (pop),
        .kill      (w_issue),
        .kill_addr (bus.w_addr),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .count     (bus.count),
        .pend_mask (bus.pend_mask)
    );

    // Register the selected write; a killed head pops as idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3_q <= '0;
            wd_q <= '0;
        end else if (w_issue) begin
            a3_q <= bus.w_addr;
            wd_q <= bus.w_data;
        end else if (pop && head.live) begin
            a3_q <= head.addr;
            wd_q <= head.data;
        end else begin
            a3_q <= '0;
            wd_q <= '0;
        end
    end

`ifdef GRF_WQ_TRACE_EN
    logic [31:0] cyc_q;

    // Free-running cycle counter for trace lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_q + 32'd1;
    end

    // Print each GRF write as it is presented.
    always @(posedge clk) begin
        if (!reset && a3_q != '0) begin
            $display("@%h: $%d <= %h", cyc_q, a3_q, wd_q);
        end
    end
`endif

endmodule

// File: tb/tb_grf_write_queue.sv
// Bench for grf_write_queue: directed scenarios then random
// traffic, all checked against a queue-based reference model.
module tb_grf_write_queue;

    localparam int DEPTH = 4;

    typedef struct {
        bit       live;
        bit [4:0] addr;
        bit [31:0] data;
    } ment_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ment_t     mq[$];
    bit [4:0]  ea3;
    bit [31:0] ewd;

    grf_write_queue_if #(.DEPTH(DEPTH)) bus ();

    grf_write_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag,
                         logic [63:0] obs,
                         logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] model_pend();
        bit [31:0] m;
        m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic check_all(string tag);
        check({tag, ".a3"}, 64'(bus.grf_a3), 64'(ea3));
        check({tag, ".wd"}, 64'(bus.grf_wd), 64'(ewd));
        check({tag, ".cnt"}, 64'(bus.count), 64'(mq.size()));
        check({tag, ".rdy"}, 64'(bus.s_ready),
              64'(mq.size() != DEPTH));
        check({tag, ".pend"}, 64'(bus.pend_mask),
              64'(model_pend()));
    endtask

    task automatic drive(bit we, bit [4:0] wa, bit [31:0] wd,
                         bit sv, bit [4:0] sa, bit [31:0] sd);
        bus.w_en    = we;
        bus.w_addr  = wa;
        bus.w_data  = wd;
        bus.s_valid = sv;
        bus.s_addr  = sa;
        bus.s_data  = sd;
    endtask

    // Advance one cycle, updating the model from the rules.
    task automatic cyc(string tag);
        bit    wi;
        bit    acc;
        ment_t e;
        wi  = bus.w_en && bus.w_addr != 0;
        acc = bus.s_valid && mq.size() < DEPTH;
        if (wi) begin
            foreach (mq[i])
                if (mq[i].addr == bus.w_addr) mq[i].live = 0;
            ea3 = bus.w_addr;
            ewd = bus.w_data;
        end else if (mq.size() > 0) begin
            e   = mq.pop_front();
            ea3 = e.live ? e.addr : 5'd0;
            ewd = e.live ? e.data : 32'd0;
        end else begin
            ea3 = 0;
            ewd = 0;
        end
        if (acc && bus.s_addr != 0) begin
            e.live = 1;
            e.addr = bus.s_addr;
            e.data = bus.s_data;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(int n);
        drive(0, 0, 0, 0, 0, 0);
        repeat (n) cyc("idle");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ea3    = 0;
        ewd    = 0;
        reset  = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.a3", 64'(bus.grf_a3), 64'd0);
        check("rst.cnt", 64'(bus.count), 64'd0);
        check("rst.rdy", 64'(bus.s_ready), 64'd1);
        check("rst.pend", 64'(bus.pend_mask), 64'd0);
        reset = 1'b0;

        // Drain: single push, no pipeline traffic.
        drive(0, 0, 0, 1, 5, 32'h1111_1111);
        cyc("drain0");
        check("drain.pend", 64'(bus.pend_mask), 64'h20);
        drive(0, 0, 0, 0, 0, 0);
        cyc("drain1");
        check("drain.a3", 64'(bus.grf_a3), 64'd5);
        check("drain.wd", 64'(bus.grf_wd), 64'h1111_1111);
        check("drain.pend0", 64'(bus.pend_mask), 64'd0);
        idle(1);

        // Priority: pipeline wins while two entries wait.
        drive(1, 3, 32'hAAAA_0000, 1, 9, 32'h99);
        cyc("prio0");
        drive(1, 3, 32'hAAAA_0000, 1, 10, 32'hA0);
        cyc("prio1");
        drive(1, 3, 32'hAAAA_0000, 0, 0, 0);
        cyc("prio2");
        check("prio.a3", 64'(bus.grf_a3), 64'd3);
        check("prio.cnt", 64'(bus.count), 64'd2);
        drive(0, 0, 0, 0, 0, 0);
        cyc("prio3");
        check("prio.fifo0", 64'(bus.grf_a3), 64'd9);
        cyc("prio4");
        check("prio.fifo1", 64'(bus.grf_a3), 64'd10);
        idle(1);

        // Full: four pushes behind continuous pipeline writes.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 3, 32'hAAAA_0000, 1, 5'(i + 10), 32'(i));
            cyc("fill");
        end
        check("full.cnt", 64'(bus.count), 64'd4);
        check("full.rdy", 64'(bus.s_ready), 64'd0);
        drive(1, 3, 32'hAAAA_0000, 1, 20, 32'h55);
        cyc("full.hold");
        check("full.cnt2", 64'(bus.count), 64'd4);
        drive(0, 0, 0, 0, 0, 0);
        cyc("full.pop");
        check("full.rdy1", 64'(bus.s_ready), 64'd1);
        idle(4);

        // Kill: pipeline write overtakes a queued write to r7.
        drive(0, 0, 0, 1, 7, 32'h1);
        cyc("kill0");
        drive(1, 7, 32'h2, 0, 0, 0);
        cyc("kill1");
        check("kill.a3", 64'(bus.grf_a3), 64'd7);
        check("kill.wd", 64'(bus.grf_wd), 64'd2);
        check("kill.pend", 64'(bus.pend_mask), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        cyc("kill2");
        check("kill.pop", 64'(bus.grf_a3), 64'd0);
        check("kill.cnt", 64'(bus.count), 64'd0);

        // Zero register on both sources.
        drive(0, 0, 0, 1, 0, 32'hDEAD);
        cyc("zero0");
        check("zero.cnt", 64'(bus.count), 64'd0);
        drive(0, 0, 0, 1, 6, 32'h66);
        cyc("zero1");
        drive(1, 0, 32'hBEEF, 0, 0, 0);
        cyc("zero2");
        check("zero.drain", 64'(bus.grf_a3), 64'd6);
        idle(1);

        // Random traffic with a small address range for kills.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 99) < 45),
                  5'($urandom_range(0, 7)),
                  $urandom,
                  ($urandom_range(0, 99) < 60),
                  5'($urandom_range(0, 7)),
                  $urandom);
            cyc("rand");
        end
        idle(6);

        // Reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 32'hAAAA_0000, 1, 5'(i + 4), 32'(i));
            cyc("pre.rst");
        end
        check("pre.cnt", 64'(bus.count), 64'd3);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        ea3 = 0;
        ewd = 0;
        check("mrst.a3", 64'(bus.grf_a3), 64'd0);
        check("mrst.cnt", 64'(bus.count), 64'd0);
        check("mrst.pend", 64'(bus.pend_mask), 64'd0);
        check("mrst.rdy", 64'(bus.s_ready), 64'd1);
        #2;
        reset = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_write_queue.md
Name: grf_write_queue

Overview:
Writer side of the general register file (GRF) single write port; it sits between the writeback stage and the GRF.
- Merges pipeline writeback (never stalls, highest priority) with a secondary long-latency result source (multiply/divide unit, slow loads) that is buffered in a small queue.
- Drives the GRF A3/WD port one write per cycle; A3 = 0 means no write.
- Exports a per-register pending mask so decode can stall on queued results.

Parameters:
DEPTH, 4, queue entries (power of two, >= 2)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
w_en  in  1  pipeline writeback valid this cycle
w_addr  in  AW  pipeline destination register
w_data  in  DW  pipeline result
s_valid  in  1  secondary source offers a write
s_ready  out  1  queue accepts secondary write (= !full)
s_addr  in  AW  secondary destination register
s_data  in  DW  secondary result
grf_a3  out  AW  to GRF A3; 0 = idle
grf_wd  out  DW  to GRF WD
pend_mask  out  32  bit i set while a live queued write to register i exists
count  out  log2(DEPTH)+1  occupied entries, including killed entries not yet popped

Behaviour:
- Reset (async): grf_a3 = 0, grf_wd = 0, queue empty, count = 0, pend_mask = 0, s_ready = 1.
- grf_a3/grf_wd are registered. A write accepted in cycle N appears on the port in cycle N+1; the GRF commits it at the edge ending N+1.
- Issue priority per cycle:
  1. w_en && w_addr != 0: issue the pipeline write.
  2. Otherwise, if the queue head exists: pop it. If the head is live, issue (addr, data); if killed, pop silently and output idle.
  3. Otherwise: output idle (grf_a3 = 0, grf_wd = 0).
- Push: s_valid && s_ready. An entry with s_addr == 0 is accepted but discarded (no push, count unchanged).
- Push and pop in the same cycle are allowed; count is unchanged.
- s_ready = (count != DEPTH), combinational from state only. There is no push-when-full, even if a pop happens the same cycle.
- Write-after-write kill: a pipeline write to r != 0 in cycle N clears the live bit of every entry holding r that was present at the start of cycle N. A push to r in the same cycle N is younger and stays live.
- pend_mask: OR of one-hot(addr) over live entries. Bit 0 is always 0. Combinational from state; a push becomes visible the cycle after acceptance.
- Pointers wrap modulo DEPTH. count saturates neither up nor down; the handshake prevents overflow and underflow.
- Reset asserted mid-operation drops all queued writes immediately; an in-flight grf_a3 is forced to 0.

Optional Feature:
GRF_WQ_TRACE_EN
- Defined: on every cycle grf_a3 != 0, print "@%h: $%d <= %h" with a cycle counter, grf_a3 and grf_wd. The 32-bit cycle counter is reset by reset.
- Undefined: no display statements and no cycle counter; the port list is identical.

Decomposition:
- Package grf_wq_pkg:
  - constants AW, DW, DEPTH default, PTR_W
  - typedef wq_entry_t {live, addr[AW], data[DW]}
- Sub-module grf_wq_ring: circular buffer with push/pop/kill-by-address and per-entry live/addr visibility for pend_mask.
- Issue mux, output register and trace stay in grf_write_queue.

Test Plan:
- Reset → idle: reset mid-stream with 3 queued entries → next cycle grf_a3 = 0, count = 0, pend_mask = 0, s_ready = 1.
- Drain: push (r5, 0x11111111) with no pipeline traffic → pend_mask = 0x20 next cycle; grf_a3 = 5, grf_wd = 0x11111111 one cycle later; then pend_mask = 0.
- Priority: w_en (r3, 0xAAAA0000) every cycle while 2 entries are queued → only r3 writes issue; queued entries drain in FIFO order once w_en drops.
- Full: 4 pushes with continuous w_en → count = 4, s_ready = 0; a 5th s_valid is held off; s_ready = 1 one cycle after w_en drops and the first pop occurs.
- Kill: queue (r7, 0x1), then pipeline w_en (r7, 0x2) → GRF sees r7 <= 0x2 only; the killed entry pops with grf_a3 = 0; pend_mask bit 7 clears the cycle after the kill.
- Zero register: s_addr = 0 push → count unchanged. w_en with w_addr = 0 → treated as idle, and the queue head drains that cycle.
